// File: rtl/dcache_port_arb.sv
// dcache_port_arb: shares the single Dcache port between speculative loads
// from the LSQ and retired stores from the SQ head. Loads normally win. A
// starvation counter or a full store queue forces the next store through.
// The winning request is registered toward the Dcache, and a load that is
// already registered can be squashed or have its mask fixed by branch
// resolution while it waits out a stall.
module dcache_port_arb #(
    parameter int STARVE_LIMIT = 4,
    parameter int BR_MASK_W    = 5,
    parameter int TAG_W        = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ld_req_i,
    input  logic [63:0]          ld_addr_i,
    input  logic [BR_MASK_W-1:0] ld_br_mask_i,
    input  logic [TAG_W-1:0]     ld_tag_i,
    input  logic                 st_req_i,
    input  logic [63:0]          st_addr_i,
    input  logic [63:0]          st_data_i,
    input  logic                 sq_full_i,
    input  logic                 dc_stall_i,
    input  logic                 rob_br_recovery_i,
    input  logic                 rob_br_pred_correct_i,
    input  logic [BR_MASK_W-1:0] rob_br_tag_fix_i,
    output logic                 ld_gnt_o,
    output logic                 st_gnt_o,
    output logic                 dc_ld_en_o,
    output logic                 dc_st_en_o,
    output logic [63:0]          dc_addr_o,
    output logic [63:0]          dc_st_data_o,
    output logic [TAG_W-1:0]     dc_tag_o,
    output logic [BR_MASK_W-1:0] dc_br_mask_o,
    output logic                 starve_o
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {
        ST_NORMAL,
        ST_FORCE
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     starve_cnt_q, starve_cnt_d;

    logic                 dc_ld_en_q, dc_ld_en_d;
    logic                 dc_st_en_q, dc_st_en_d;
    logic [63:0]          dc_addr_q, dc_addr_d;
    logic [63:0]          dc_st_data_q, dc_st_data_d;
    logic [TAG_W-1:0]     dc_tag_q, dc_tag_d;
    logic [BR_MASK_W-1:0] dc_br_mask_q, dc_br_mask_d;

    logic                 ld_squash;
    logic                 ld_vld;
    logic                 ld_gnt;
    logic                 st_gnt;
    logic                 starve_inc;
    logic [BR_MASK_W-1:0] mask_fix;

    // Pick at most one winner for the port this cycle; nothing is granted while in reset
    always_comb begin
        ld_squash = rob_br_recovery_i & (|(ld_br_mask_i & rob_br_tag_fix_i));
        ld_vld    = ld_req_i & ~ld_squash;
        ld_gnt    = 1'b0;
        st_gnt    = 1'b0;
        if (!rst && !dc_stall_i) begin
            if (state_q == ST_NORMAL) begin
                ld_gnt = ld_vld;
                st_gnt = ~ld_vld & st_req_i;
            end else begin
                st_gnt = st_req_i;
            end
        end
    end

    // Track how long a waiting store has lost to loads and decide when to force it through
    always_comb begin
        starve_inc   = st_req_i & ld_gnt;
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        if (st_gnt || !st_req_i) begin
            starve_cnt_d = '0;
        end else if (starve_inc && (starve_cnt_q < CNT_W'(STARVE_LIMIT))) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
        case (state_q)
            ST_NORMAL: begin
                if (!st_gnt &&
                    ((starve_inc && (starve_cnt_q == CNT_W'(STARVE_LIMIT - 1))) ||
                     (sq_full_i && st_req_i))) begin
                    state_d = ST_FORCE;
                end
            end
            ST_FORCE: begin
                if (st_gnt || !st_req_i) begin
                    state_d = ST_NORMAL;
                end
            end
            default: state_d = ST_NORMAL;
        endcase
    end

    // Next value of the Dcache request register: capture, go idle, or hold with branch fixes
    always_comb begin
        mask_fix     = rob_br_pred_correct_i ? rob_br_tag_fix_i : '0;
        dc_ld_en_d   = dc_ld_en_q;
        dc_st_en_d   = dc_st_en_q;
        dc_addr_d    = dc_addr_q;
        dc_st_data_d = dc_st_data_q;
        dc_tag_d     = dc_tag_q;
        dc_br_mask_d = dc_br_mask_q;
        if (st_gnt) begin
            dc_ld_en_d   = 1'b0;
            dc_st_en_d   = 1'b1;
            dc_addr_d    = st_addr_i;
            dc_st_data_d = st_data_i;
            dc_tag_d     = '0;
            dc_br_mask_d = '0;
        end else if (ld_gnt) begin
            dc_ld_en_d   = 1'b1;
            dc_st_en_d   = 1'b0;
            dc_addr_d    = ld_addr_i;
            dc_st_data_d = '0;
            dc_tag_d     = ld_tag_i;
            dc_br_mask_d = ld_br_mask_i & ~mask_fix;
        end else if (!dc_stall_i) begin
            dc_ld_en_d   = 1'b0;
            dc_st_en_d   = 1'b0;
            dc_addr_d    = '0;
            dc_st_data_d = '0;
            dc_tag_d     = '0;
            dc_br_mask_d = '0;
        end else if (rob_br_recovery_i && (|(dc_br_mask_q & rob_br_tag_fix_i))) begin
            dc_ld_en_d   = 1'b0;
            dc_tag_d     = '0;
            dc_br_mask_d = '0;
        end else begin
            dc_br_mask_d = dc_br_mask_q & ~mask_fix;
        end
    end

    // State, counter and request register update
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_NORMAL;
            starve_cnt_q <= '0;
            dc_ld_en_q   <= 1'b0;
            dc_st_en_q   <= 1'b0;
            dc_addr_q    <= '0;
            dc_st_data_q <= '0;
            dc_tag_q     <= '0;
            dc_br_mask_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            dc_ld_en_q   <= dc_ld_en_d;
            dc_st_en_q   <= dc_st_en_d;
            dc_addr_q    <= dc_addr_d;
            dc_st_data_q <= dc_st_data_d;
            dc_tag_q     <= dc_tag_d;
            dc_br_mask_q <= dc_br_mask_d;
        end
    end

    assign ld_gnt_o     = ld_gnt;
    assign st_gnt_o     = st_gnt;
    assign dc_ld_en_o   = dc_ld_en_q;
    assign dc_st_en_o   = dc_st_en_q;
    assign dc_addr_o    = dc_addr_q;
    assign dc_st_data_o = dc_st_data_q;
    assign dc_tag_o     = dc_tag_q;
    assign dc_br_mask_o = dc_br_mask_q;
    assign starve_o     = (state_q == ST_FORCE);

endmodule

// File: tb/tb_dcache_port_arb.sv
// tb_dcache_port_arb: directed scenarios followed by random traffic, every
// cycle compared against a behavioural model of the port arbiter.
module tb_dcache_port_arb;

    localparam int STARVE_LIMIT = 4;
    localparam int BR_MASK_W    = 5;
    localparam int TAG_W        = 6;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 ld_req_i;
    logic [63:0]          ld_addr_i;
    logic [BR_MASK_W-1:0] ld_br_mask_i;
    logic [TAG_W-1:0]     ld_tag_i;
    logic                 st_req_i;
    logic [63:0]          st_addr_i;
    logic [63:0]          st_data_i;
    logic                 sq_full_i;
    logic                 dc_stall_i;
    logic                 rob_br_recovery_i;
    logic                 rob_br_pred_correct_i;
    logic [BR_MASK_W-1:0] rob_br_tag_fix_i;
    logic                 ld_gnt_o;
    logic                 st_gnt_o;
    logic                 dc_ld_en_o;
    logic                 dc_st_en_o;
    logic [63:0]          dc_addr_o;
    logic [63:0]          dc_st_data_o;
    logic [TAG_W-1:0]     dc_tag_o;
    logic [BR_MASK_W-1:0] dc_br_mask_o;
    logic                 starve_o;

    dcache_port_arb #(
        .STARVE_LIMIT(STARVE_LIMIT),
        .BR_MASK_W   (BR_MASK_W),
        .TAG_W       (TAG_W)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .ld_req_i             (ld_req_i),
        .ld_addr_i            (ld_addr_i),
        .ld_br_mask_i         (ld_br_mask_i),
        .ld_tag_i             (ld_tag_i),
        .st_req_i             (st_req_i),
        .st_addr_i            (st_addr_i),
        .st_data_i            (st_data_i),
        .sq_full_i            (sq_full_i),
        .dc_stall_i           (dc_stall_i),
        .rob_br_recovery_i    (rob_br_recovery_i),
        .rob_br_pred_correct_i(rob_br_pred_correct_i),
        .rob_br_tag_fix_i     (rob_br_tag_fix_i),
        .ld_gnt_o             (ld_gnt_o),
        .st_gnt_o             (st_gnt_o),
        .dc_ld_en_o           (dc_ld_en_o),
        .dc_st_en_o           (dc_st_en_o),
        .dc_addr_o            (dc_addr_o),
        .dc_st_data_o         (dc_st_data_o),
        .dc_tag_o             (dc_tag_o),
        .dc_br_mask_o         (dc_br_mask_o),
        .starve_o             (starve_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Stimulus for the next cycle
    bit                 c_rst, c_ld_req, c_st_req, c_sq_full, c_stall, c_rec, c_pred;
    logic [63:0]        c_ld_addr, c_st_addr, c_st_data;
    logic [4:0]         c_ld_mask, c_fix;
    logic [5:0]         c_ld_tag;

    // Reference model: store-forcing mode, loads lost by the waiting store,
    // and the request currently presented to the Dcache
    bit                 m_force;
    int                 m_losses;
    bit                 m_ld_en, m_st_en;
    logic [63:0]        m_addr, m_data;
    logic [5:0]         m_tag;
    logic [4:0]         m_mask;
    bit                 e_ld, e_st, squash_req;

    // Observed grant/starve values of the last cycle, for directed checks
    bit                 obs_ld_gnt, obs_st_gnt, obs_starve;

    // Compare one observed value against its expected value
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Clear stimulus to an idle cycle
    task automatic setIdle();
        c_rst = 0; c_ld_req = 0; c_st_req = 0; c_sq_full = 0; c_stall = 0;
        c_rec = 0; c_pred = 0; c_fix = '0;
        c_ld_addr = '0; c_ld_mask = '0; c_ld_tag = '0; c_st_addr = '0; c_st_data = '0;
    endtask

    // Drive one cycle of stimulus, check grants, advance the model, check the registered request
    task automatic applyStimulus();
        rst                   = c_rst;
        ld_req_i              = c_ld_req;
        ld_addr_i             = c_ld_addr;
        ld_br_mask_i          = c_ld_mask;
        ld_tag_i              = c_ld_tag;
        st_req_i              = c_st_req;
        st_addr_i             = c_st_addr;
        st_data_i             = c_st_data;
        sq_full_i             = c_sq_full;
        dc_stall_i            = c_stall;
        rob_br_recovery_i     = c_rec;
        rob_br_pred_correct_i = c_pred;
        rob_br_tag_fix_i      = c_fix;
        #1;
        squash_req = c_rec && ((c_ld_mask & c_fix) != 0);
        e_ld = 0;
        e_st = 0;
        if (!c_rst && !c_stall) begin
            if (m_force) e_st = c_st_req;
            else if (c_ld_req && !squash_req) e_ld = 1;
            else e_st = c_st_req;
        end
        obs_ld_gnt = ld_gnt_o;
        obs_st_gnt = st_gnt_o;
        obs_starve = starve_o;
        checkOutput("ld_gnt", ld_gnt_o, e_ld);
        checkOutput("st_gnt", st_gnt_o, e_st);
        checkOutput("starve", starve_o, m_force);
        if (c_rst) begin
            m_force = 0; m_losses = 0;
            m_ld_en = 0; m_st_en = 0; m_addr = '0; m_data = '0; m_tag = '0; m_mask = '0;
        end else begin
            if (m_force) begin
                if (e_st || !c_st_req) begin
                    m_force = 0;
                    m_losses = 0;
                end
            end else begin
                if (!e_st && c_st_req &&
                    (c_sq_full || (e_ld && (m_losses + 1 == STARVE_LIMIT))))
                    m_force = 1;
                if (e_st || !c_st_req) m_losses = 0;
                else if (e_ld) m_losses = (m_losses + 1 > STARVE_LIMIT) ? STARVE_LIMIT : m_losses + 1;
            end
            if (e_st) begin
                m_ld_en = 0; m_st_en = 1; m_addr = c_st_addr; m_data = c_st_data;
                m_tag = '0; m_mask = '0;
            end else if (e_ld) begin
                m_ld_en = 1; m_st_en = 0; m_addr = c_ld_addr; m_data = '0; m_tag = c_ld_tag;
                m_mask = c_pred ? (c_ld_mask & ~c_fix) : c_ld_mask;
            end else if (!c_stall) begin
                m_ld_en = 0; m_st_en = 0; m_addr = '0; m_data = '0; m_tag = '0; m_mask = '0;
            end else if (c_rec && ((m_mask & c_fix) != 0)) begin
                m_ld_en = 0; m_tag = '0; m_mask = '0;
            end else if (c_pred) begin
                m_mask = m_mask & ~c_fix;
            end
        end
        @(posedge clk);
        #1;
        checkOutput("dc_ld_en", dc_ld_en_o, m_ld_en);
        checkOutput("dc_st_en", dc_st_en_o, m_st_en);
        checkOutput("dc_addr", dc_addr_o, m_addr);
        checkOutput("dc_st_data", dc_st_data_o, m_data);
        checkOutput("dc_tag", dc_tag_o, m_tag);
        checkOutput("dc_br_mask", dc_br_mask_o, m_mask);
    endtask

    // Two cycles of reset followed by idle stimulus
    task automatic doReset();
        setIdle();
        c_rst = 1;
        applyStimulus();
        applyStimulus();
        c_rst = 0;
    endtask

    int first_st, ld_before, pre_ld;
    bit starve_at;

    initial begin
        setIdle();
        c_rst = 1;
        rst = 1; ld_req_i = 0; ld_addr_i = '0; ld_br_mask_i = '0; ld_tag_i = '0;
        st_req_i = 0; st_addr_i = '0; st_data_i = '0; sq_full_i = 0; dc_stall_i = 0;
        rob_br_recovery_i = 0; rob_br_pred_correct_i = 0; rob_br_tag_fix_i = '0;
        @(posedge clk);
        #1;
        doReset();

        // Lone load is granted at once and presented one cycle later
        c_ld_req = 1; c_ld_addr = 64'h100; c_ld_tag = 6'd9;
        applyStimulus();
        checkOutput("t1_ld_gnt", obs_ld_gnt, 1);
        checkOutput("t1_addr", dc_addr_o, 64'h100);
        checkOutput("t1_ld_en", dc_ld_en_o, 1);

        // Load and store both held: four loads win, then the store is forced
        doReset();
        c_ld_req = 1; c_ld_addr = 64'h180; c_st_req = 1; c_st_addr = 64'h2000; c_st_data = 64'hdead_beef;
        first_st = 0; ld_before = 0; starve_at = 0;
        for (int i = 1; i <= 6; i++) begin
            applyStimulus();
            if (obs_st_gnt && first_st == 0) begin
                first_st = i;
                starve_at = obs_starve;
            end
            if (obs_ld_gnt && first_st == 0) ld_before++;
        end
        checkOutput("starve_first_st", first_st, 5);
        checkOutput("starve_ld_count", ld_before, 4);
        checkOutput("starve_flag", starve_at, 1);

        // Full store queue lets at most one load through before the store
        doReset();
        c_ld_req = 1; c_ld_addr = 64'h1c0; c_st_req = 1; c_st_addr = 64'h3000; c_sq_full = 1;
        first_st = 0; pre_ld = 0;
        for (int i = 1; i <= 3; i++) begin
            applyStimulus();
            if (obs_st_gnt && first_st == 0) first_st = i;
            if (obs_ld_gnt && first_st == 0) pre_ld++;
        end
        checkOutput("sqfull_pre_ld", pre_ld <= 1, 1);
        checkOutput("sqfull_st_seen", first_st != 0, 1);

        // Stall holds the registered request; release grants in the same cycle
        doReset();
        c_ld_req = 1; c_ld_addr = 64'h200; c_ld_tag = 6'd3;
        applyStimulus();
        c_ld_addr = 64'h240; c_st_req = 1; c_st_addr = 64'h4000; c_stall = 1;
        for (int i = 0; i < 3; i++) applyStimulus();
        checkOutput("stall_addr_held", dc_addr_o, 64'h200);
        c_stall = 0;
        applyStimulus();
        checkOutput("stall_release_gnt", obs_ld_gnt, 1);

        // Recovery squashes a registered load only when its mask matches
        doReset();
        c_ld_req = 1; c_ld_addr = 64'h300; c_ld_mask = 5'b00010; c_ld_tag = 6'd5;
        applyStimulus();
        setIdle();
        c_stall = 1; c_rec = 1; c_fix = 5'b00100;
        applyStimulus();
        checkOutput("squash_nomatch", dc_ld_en_o, 1);
        c_fix = 5'b00010;
        applyStimulus();
        checkOutput("squash_match", dc_ld_en_o, 0);

        // Correct prediction clears the resolved bit of the registered mask
        doReset();
        c_ld_req = 1; c_ld_addr = 64'h340; c_ld_mask = 5'b00011;
        applyStimulus();
        setIdle();
        c_stall = 1; c_pred = 1; c_fix = 5'b00010;
        applyStimulus();
        checkOutput("pred_fix_mask", dc_br_mask_o, 5'b00001);

        // Reset in the middle of a request clears everything
        setIdle();
        c_ld_req = 1; c_ld_addr = 64'h380;
        applyStimulus();
        c_rst = 1;
        applyStimulus();
        checkOutput("midrst_ld_en", dc_ld_en_o, 0);
        c_rst = 0;

        // Random traffic; request fields stay put until granted
        setIdle();
        for (int n = 0; n < 3000; n++) begin
            if (!c_ld_req || e_ld || squash_req || c_rst) begin
                c_ld_req  = ($urandom_range(0, 99) < 60);
                c_ld_addr = {$urandom, $urandom};
                c_ld_mask = 5'($urandom);
                c_ld_tag  = 6'($urandom);
            end
            if (!c_st_req || e_st || c_rst) begin
                c_st_req  = ($urandom_range(0, 99) < 50);
                c_st_addr = {$urandom, $urandom};
                c_st_data = {$urandom, $urandom};
            end
            c_rst     = ($urandom_range(0, 199) == 0);
            c_stall   = ($urandom_range(0, 99) < 20);
            c_sq_full = ($urandom_range(0, 99) < 15);
            c_rec     = ($urandom_range(0, 99) < 10);
            c_pred    = !c_rec && ($urandom_range(0, 99) < 15);
            c_fix     = 5'(1 << $urandom_range(0, 4));
            applyStimulus();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
